// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder/subtractor, DIGIT bits per clock.
// Registered S/carryout/overflow with a start/busy/done handshake.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             carryin,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] S,
    output logic             carryout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] d;
    logic             cmsb;

    // One digit of the narrow carry chain, plus the carry into its top bit.
    always_comb begin
        sum  = {1'b0, a[DIGIT-1:0]} + {1'b0, b[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, c};
        d    = sum[DIGIT-1:0];
        cmsb = d[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
    end

    generate
        if (WIDTH > DIGIT) begin : g_shift
            assign res_next = {d, res[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign res_next = d;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN for NDIG digits -> DONE -> IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, digit-serial datapath and final result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            res      <= '0;
            S        <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            a   <= X;
            b   <= sub ? ~Y : Y;
            c   <= sub ? 1'b1 : carryin;
            cnt <= '0;
        end else if (state == RUN) begin
            a   <= a >> DIGIT;
            b   <= b >> DIGIT;
            c   <= sum[DIGIT];
            res <= res_next;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
                S        <= res_next;
                carryout <= sum[DIGIT];
                overflow <= sum[DIGIT] ^ cmsb;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: directed and sweep checks of seq_adder
// across several WIDTH/DIGIT configurations.
module tb_seq_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    logic        st[5];
    logic        sb[5];
    logic        ci[5];
    logic [15:0] xv[5];
    logic [15:0] yv[5];

    logic [7:0]  s0;
    logic [3:0]  s1;
    logic [15:0] s2, s3, s4;
    logic        co[5];
    logic        ov[5];
    logic        bz[5];
    logic        dn[5];

    seq_adder #(.WIDTH(8), .DIGIT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]),
        .carryin(ci[0]), .X(xv[0][7:0]), .Y(yv[0][7:0]), .S(s0),
        .carryout(co[0]), .overflow(ov[0]), .busy(bz[0]), .done(dn[0]));
    seq_adder #(.WIDTH(4), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]),
        .carryin(ci[1]), .X(xv[1][3:0]), .Y(yv[1][3:0]), .S(s1),
        .carryout(co[1]), .overflow(ov[1]), .busy(bz[1]), .done(dn[1]));
    seq_adder #(.WIDTH(16), .DIGIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sb[2]),
        .carryin(ci[2]), .X(xv[2]), .Y(yv[2]), .S(s2),
        .carryout(co[2]), .overflow(ov[2]), .busy(bz[2]), .done(dn[2]));
    seq_adder #(.WIDTH(16), .DIGIT(4)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .sub(sb[3]),
        .carryin(ci[3]), .X(xv[3]), .Y(yv[3]), .S(s3),
        .carryout(co[3]), .overflow(ov[3]), .busy(bz[3]), .done(dn[3]));
    seq_adder #(.WIDTH(16), .DIGIT(16)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st[4]), .sub(sb[4]),
        .carryin(ci[4]), .X(xv[4]), .Y(yv[4]), .S(s4),
        .carryout(co[4]), .overflow(ov[4]), .busy(bz[4]), .done(dn[4]));

    function automatic logic [15:0] sval(input int k);
        case (k)
            0: return {8'h00, s0};
            1: return {12'h000, s1};
            2: return s2;
            3: return s3;
            default: return s4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Golden model: S = X + (sub ? ~Y+1 : Y+carryin), modulo 2^w.
    task automatic model(input int w, input logic [15:0] x,
                         input logic [15:0] y, input logic s,
                         input logic cin, output logic [15:0] es,
                         output logic eco, output logic eov);
        logic [16:0] mask, bb, full;
        logic [16:0] xx;
        mask = (17'd1 << w) - 17'd1;
        xx   = {1'b0, x} & mask;
        bb   = s ? (~{1'b0, y} & mask) : ({1'b0, y} & mask);
        full = xx + bb + {16'd0, (s ? 1'b1 : cin)};
        es   = full[15:0] & mask[15:0];
        eco  = full[w];
        eov  = (xx[w-1] == bb[w-1]) && (full[w-1] != xx[w-1]);
    endtask

    // Start one operation on instance k and wait (bounded) for done.
    task automatic run_op(input int k, input logic [15:0] x,
                          input logic [15:0] y, input logic s,
                          input logic cin, output logic [15:0] rs,
                          output logic rco, output logic rov,
                          output int lat);
        @(negedge clk);
        xv[k] = x; yv[k] = y; sb[k] = s; ci[k] = cin; st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
        lat = 0;
        while (!dn[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rs = sval(k); rco = co[k]; rov = ov[k];
    endtask

    task automatic op_chk(input string tag, input int k, input int w,
                          input int ndig, input logic [15:0] x,
                          input logic [15:0] y, input logic s,
                          input logic cin);
        logic [15:0] rs, es;
        logic rco, rov, eco, eov;
        int lat;
        run_op(k, x, y, s, cin, rs, rco, rov, lat);
        model(w, x, y, s, cin, es, eco, eov);
        chk({tag, ".lat"}, lat, ndig);
        chk({tag, ".S"}, {16'd0, rs}, {16'd0, es});
        chk({tag, ".co"}, {31'd0, rco}, {31'd0, eco});
        chk({tag, ".ov"}, {31'd0, rov}, {31'd0, eov});
    endtask

    task automatic op_exp(input string tag, input logic [7:0] x,
                          input logic [7:0] y, input logic s,
                          input logic cin, input logic [7:0] es,
                          input logic eco, input logic eov);
        logic [15:0] rs;
        logic rco, rov;
        int lat;
        run_op(0, {8'd0, x}, {8'd0, y}, s, cin, rs, rco, rov, lat);
        chk({tag, ".lat"}, lat, 4);
        chk({tag, ".S"}, {16'd0, rs}, {24'd0, es});
        chk({tag, ".co"}, {31'd0, rco}, {31'd0, eco});
        chk({tag, ".ov"}, {31'd0, rov}, {31'd0, eov});
    endtask

    initial begin
        int nb, nd, cyc;
        logic [15:0] rx, ry;
        for (int k = 0; k < 5; k++) begin
            st[k] = 0; sb[k] = 0; ci[k] = 0; xv[k] = 0; yv[k] = 0;
        end

        // Reset state.
        #12;
        chk("rst.S", {24'd0, s0}, 0);
        chk("rst.co", {31'd0, co[0]}, 0);
        chk("rst.busy", {31'd0, bz[0]}, 0);
        chk("rst.done", {31'd0, dn[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: 00+00 with done/busy timing.
        @(negedge clk);
        xv[0] = 0; yv[0] = 0; sb[0] = 0; ci[0] = 0; st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        nb = 0; nd = 0; cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (bz[0]) nb++;
            if (dn[0]) begin
                nd++;
                cyc = i;
            end
            @(negedge clk);
        end
        chk("t1.busy_cycles", nb, 5);
        chk("t1.done_count", nd, 1);
        chk("t1.done_at", cyc, 4);
        chk("t1.S", {24'd0, s0}, 0);
        chk("t1.co", {31'd0, co[0]}, 0);
        chk("t1.ov", {31'd0, ov[0]}, 0);

        // Test 2: add boundaries.
        op_exp("t2.ff_ff_c0", 8'hFF, 8'hFF, 0, 0, 8'hFE, 1, 0);
        op_exp("t2.ff_ff_c1", 8'hFF, 8'hFF, 0, 1, 8'hFF, 1, 0);
        op_exp("t2.7f_01", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
        op_exp("t2.80_80", 8'h80, 8'h80, 0, 0, 8'h00, 1, 1);

        // Test 3: subtract, carryin held high.
        op_exp("t3.05_0a", 8'h05, 8'h0A, 1, 1, 8'hFB, 0, 0);
        op_exp("t3.80_01", 8'h80, 8'h01, 1, 1, 8'h7F, 1, 1);
        op_exp("t3.0a_0a", 8'h0A, 8'h0A, 1, 1, 8'h00, 1, 0);

        // Test 4a: second start during RUN is ignored.
        @(negedge clk);
        xv[0] = 16'h11; yv[0] = 16'h22; sb[0] = 0; ci[0] = 0; st[0] = 1;
        @(negedge clk);
        st[0] = 0; xv[0] = 16'h55; yv[0] = 16'h66; sb[0] = 1;
        @(negedge clk);
        st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (dn[0]) nd++;
            @(negedge clk);
        end
        chk("t4.one_done", nd, 1);
        chk("t4.S", {24'd0, s0}, 32'h33);
        chk("t4.busy_idle", {31'd0, bz[0]}, 0);

        // Test 4b: S holds until the next operation's done.
        xv[0] = 16'hF0; yv[0] = 16'h55; sb[0] = 0; ci[0] = 0; st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        nb = 0;
        cyc = 0;
        while (!dn[0] && cyc < 40) begin
            if (s0 != 8'h33) nb++;
            @(negedge clk);
            cyc++;
        end
        chk("t4.hold_lat", cyc, 4);
        chk("t4.hold_S", nb, 0);
        chk("t4.next_S", {24'd0, s0}, 32'h45);
        chk("t4.next_co", {31'd0, co[0]}, 1);

        // Test 4c: async reset at t2 aborts.
        @(negedge clk);
        xv[0] = 16'h10; yv[0] = 16'h20; st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4.rst_S", {24'd0, s0}, 0);
        chk("t4.rst_co", {31'd0, co[0]}, 0);
        chk("t4.rst_ov", {31'd0, ov[0]}, 0);
        chk("t4.rst_busy", {31'd0, bz[0]}, 0);
        chk("t4.rst_done", {31'd0, dn[0]}, 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        chk("t4.rst_no_done", nd, 0);
        op_exp("t4.after_rst", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);

        // Test 5: exhaustive WIDTH=4, DIGIT=1.
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        op_chk("t5", 1, 4, 4, 16'(x), 16'(y),
                               s[0], c[0]);

        // Test 6: WIDTH=16 with DIGIT=1, 4, 16.
        for (int k = 2; k < 5; k++) begin
            for (int i = 0; i < 1000; i++) begin
                rx = 16'($urandom);
                ry = 16'($urandom);
                op_chk("t6", k, 16,
                       (k == 2) ? 16 : ((k == 3) ? 4 : 1),
                       rx, ry, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
